// File: rtl/sd_resp_rx_if.sv
// SD CMD-line response receiver port bundle: arm/sample controls in, frame fields and status out.
// The master drives tick/cmd_in/start/long_resp; the receiver (slave) returns busy/done and results.
interface sd_resp_rx_if;
  logic         tick;
  logic         cmd_in;
  logic         start;
  logic         long_resp;
  logic         busy;
  logic         done;
  logic [119:0] resp_data;
  logic [6:0]   resp_crc;
  logic         crc_err;
  logic         frame_err;
  logic         timeout;

  modport master (
    output tick, cmd_in, start, long_resp,
    input  busy, done, resp_data, resp_crc, crc_err, frame_err, timeout
  );

  modport slave (
    input  tick, cmd_in, start, long_resp,
    output busy, done, resp_data, resp_crc, crc_err, frame_err, timeout
  );
endinterface

// File: rtl/sd_resp_rx.sv
// SD card response receiver: waits for a start bit, shifts in a 48/136-bit frame, checks CRC7/framing.
// done pulses one clk after the tick that samples the end bit (or the final timeout tick).
module sd_resp_rx #(
  parameter int TIMEOUT_TICKS = 64,
  parameter int TO_BITS       = 8
) (
  input  logic        clk,
  input  logic        reset,
  sd_resp_rx_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RECV = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic               is_long;
  logic [TO_BITS-1:0] to_cnt;
  logic [7:0]         bit_cnt;
  logic [127:0]       sr;
  logic [6:0]         crc;
  logic               crc_err_q;
  logic               frame_err_q;
  logic               timeout_q;

  logic [7:0] last_idx;
  logic [7:0] crc_lo;
  logic [7:0] crc_hi;
  logic       in_crc;
  logic       crc_fb;
  logic [6:0] crc_next;

  // bit_cnt counts bits already received, so the bit on the line is frame bit (last_idx - bit_cnt).
  // The long-response header (start, transmission, reserved) is excluded from its CRC.
  always_comb begin
    last_idx = is_long ? 8'd135 : 8'd47;
    crc_lo   = is_long ? 8'd8 : 8'd1;
    crc_hi   = last_idx - 8'd8;
    in_crc   = (bit_cnt >= crc_lo) && (bit_cnt <= crc_hi);
    crc_fb   = crc[6] ^ bus.cmd_in;
    crc_next = {crc[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      is_long     <= 1'b0;
      to_cnt      <= '0;
      bit_cnt     <= '0;
      sr          <= '0;
      crc         <= '0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            is_long     <= bus.long_resp;
            to_cnt      <= '0;
            bit_cnt     <= '0;
            sr          <= '0;
            crc         <= '0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.tick) begin
            if (!bus.cmd_in) begin
              // Start bit is zero, so it leaves the zero-initialised CRC untouched.
              bit_cnt <= 8'd1;
              sr      <= {sr[126:0], 1'b0};
              state   <= S_RECV;
            end else begin
              to_cnt <= to_cnt + TO_BITS'(1);
              if (to_cnt == TO_BITS'(TIMEOUT_TICKS - 1)) begin
                timeout_q <= 1'b1;
                state     <= S_DONE;
              end
            end
          end
        end
        S_RECV: begin
          if (bus.tick) begin
            sr      <= {sr[126:0], bus.cmd_in};
            bit_cnt <= bit_cnt + 8'd1;
            if (in_crc)
              crc <= crc_next;
            if (bit_cnt == 8'd1 && bus.cmd_in)
              frame_err_q <= 1'b1;
            if (bit_cnt == last_idx) begin
              // sr[6:0] holds the received CRC field before this end-bit shift.
              if (!bus.cmd_in)
                frame_err_q <= 1'b1;
              crc_err_q <= (crc != sr[6:0]);
              state     <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.resp_data = is_long ? sr[127:8] : {82'd0, sr[45:8]};
  assign bus.resp_crc  = sr[7:1];
  assign bus.crc_err   = crc_err_q;
  assign bus.frame_err = frame_err_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_sd_resp_rx.sv
// Bench for sd_resp_rx: scenario tasks with randomized frames checked against a polynomial-division model.
module tb_sd_resp_rx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  sd_resp_rx_if bus();

  sd_resp_rx #(.TIMEOUT_TICKS(64), .TO_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;

  always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

  typedef struct packed {
    logic         done_pre;
    logic         done;
    logic         done_post;
    logic         busy_post;
    logic         busy_mid;
    logic         held;
    logic [7:0]   pulses;
    logic [119:0] data;
    logic [6:0]   crc;
    logic         ce;
    logic         fe;
    logic         to;
  } obs_t;

  localparam logic [13:0] TIM_OK = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1};

  // CRC7 as remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7_ref(input logic [135:0] f, input int hi, input int lo);
    bit q[$];
    logic [6:0] r;
    for (int i = hi; i >= lo; i--) q.push_back(f[i]);
    repeat (7) q.push_back(1'b0);
    for (int i = 0; i + 7 < q.size(); i++)
      if (q[i]) begin
        q[i]   ^= 1'b1;
        q[i+4] ^= 1'b1;
        q[i+7] ^= 1'b1;
      end
    for (int k = 0; k < 7; k++) r[6-k] = q[q.size()-7+k];
    return r;
  endfunction

  function automatic logic [135:0] short_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [135:0] f;
    f = '0;
    f[45:40] = idx;
    f[39:8]  = arg;
    f[7:1]   = crc7_ref(f, 47, 8);
    f[0]     = 1'b1;
    return f;
  endfunction

  function automatic logic [135:0] long_frame(input logic [119:0] p);
    logic [135:0] f;
    f = '0;
    f[133:128] = 6'h3F;
    f[127:8]   = p;
    f[7:1]     = crc7_ref(f, 127, 8);
    f[0]       = 1'b1;
    return f;
  endfunction

  // Expected {resp_data, resp_crc, crc_err, frame_err, timeout} for a received frame.
  function automatic logic [129:0] exp_status(input logic [135:0] f, input bit lng);
    int n;
    logic [119:0] d;
    logic ce, fe;
    n  = lng ? 136 : 48;
    d  = lng ? f[127:8] : {82'd0, f[45:8]};
    ce = (crc7_ref(f, lng ? 127 : 47, 8) != f[7:1]);
    fe = f[n-2] | ~f[0];
    return {d, f[7:1], ce, fe, 1'b0};
  endfunction

  task automatic send_bit(input logic b);
    bus.cmd_in = b;
    repeat (3) @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
  endtask

  task automatic run_frame(input logic [135:0] f, input bit lng, input int idle, input int inj, output obs_t o);
    int n, c0;
    n = lng ? 136 : 48;
    c0 = done_cnt;
    o = '0;
    bus.long_resp = lng;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.long_resp = 1'($urandom);
    repeat (idle) send_bit(1'b1);
    for (int i = n - 1; i >= 1; i--) begin
      if (i == inj) begin
        bus.start = 1'b1;
        bus.long_resp = ~lng;
        @(negedge clk);
        bus.start = 1'b0;
      end
      send_bit(f[i]);
      if (i == n / 2) o.busy_mid = bus.busy;
    end
    bus.cmd_in = f[0];
    repeat (3) @(negedge clk);
    bus.tick = 1'b1;
    o.done_pre = bus.done;
    @(negedge clk);
    bus.tick = 1'b0;
    o.done = bus.done;
    o.data = bus.resp_data;
    o.crc  = bus.resp_crc;
    o.ce   = bus.crc_err;
    o.fe   = bus.frame_err;
    o.to   = bus.timeout;
    bus.cmd_in = 1'b1;
    @(negedge clk);
    o.done_post = bus.done;
    o.busy_post = bus.busy;
    o.held = (bus.resp_data === o.data) && (bus.resp_crc === o.crc);
    o.pulses = 8'(done_cnt - c0);
  endtask

  task automatic test_reset();
    n_chk++;
    if ({bus.busy, bus.done, bus.resp_data, bus.resp_crc, bus.crc_err, bus.frame_err, bus.timeout} !== '0)
      $display("FAIL reset_held: got busy=%b done=%b data=%h crc=%h flags=%b%b%b, want all 0", bus.busy, bus.done,
               bus.resp_data, bus.resp_crc, bus.crc_err, bus.frame_err, bus.timeout);
    else n_pass++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({bus.busy, bus.done, bus.resp_data, bus.resp_crc, bus.crc_err, bus.frame_err, bus.timeout} !== '0)
      $display("FAIL reset_release: got busy=%b done=%b data=%h, want all 0", bus.busy, bus.done, bus.resp_data);
    else n_pass++;
  endtask

  task automatic test_cmd0();
    obs_t o;
    logic [135:0] f;
    f = {88'd0, 48'h40_00_00_00_00_95};
    run_frame(f, 1'b0, 3, -1, o);
    n_chk++;
    if ({o.data, o.crc, o.ce, o.fe, o.to} !== exp_status(f, 1'b0))
      $display("FAIL cmd0_status: got %h want %h", {o.data, o.crc, o.ce, o.fe, o.to}, exp_status(f, 1'b0));
    else n_pass++;
    n_chk++;
    if (o.crc !== 7'h4A || o.fe !== 1'b1 || o.ce !== 1'b0 || o.data !== '0)
      $display("FAIL cmd0_fixed: got crc=%h fe=%b ce=%b data=%h want crc=4a fe=1 ce=0 data=0", o.crc, o.fe, o.ce, o.data);
    else n_pass++;
    n_chk++;
    if ({o.done_pre, o.done, o.done_post, o.busy_post, o.busy_mid, o.held, o.pulses} !== TIM_OK)
      $display("FAIL cmd0_timing: got %b want %b", {o.done_pre, o.done, o.done_post, o.busy_post, o.busy_mid, o.held, o.pulses}, TIM_OK);
    else n_pass++;
  endtask

  task automatic test_short_valid();
    obs_t o;
    logic [135:0] f, g;
    f = short_frame(6'd8, 32'h0000_01AA);
    run_frame(f, 1'b0, 0, -1, o);
    n_chk++;
    if (o.data[37:0] !== 38'h8000001AA || o.ce !== 1'b0 || o.fe !== 1'b0 || o.to !== 1'b0)
      $display("FAIL cmd8_fields: got data=%h ce=%b fe=%b to=%b want data=8000001aa flags=000", o.data[37:0], o.ce, o.fe, o.to);
    else n_pass++;
    n_chk++;
    if ({o.data, o.crc, o.ce, o.fe, o.to} !== exp_status(f, 1'b0))
      $display("FAIL cmd8_status: got %h want %h", {o.data, o.crc, o.ce, o.fe, o.to}, exp_status(f, 1'b0));
    else n_pass++;
    g = f;
    g[8] = ~g[8];
    run_frame(g, 1'b0, 2, -1, o);
    n_chk++;
    if (o.ce !== 1'b1 || o.fe !== 1'b0)
      $display("FAIL cmd8_argflip: got ce=%b fe=%b want ce=1 fe=0", o.ce, o.fe);
    else n_pass++;
    g = f;
    g[0] = 1'b0;
    run_frame(g, 1'b0, 1, -1, o);
    n_chk++;
    if (o.fe !== 1'b1 || o.ce !== 1'b0)
      $display("FAIL cmd8_endbit: got fe=%b ce=%b want fe=1 ce=0", o.fe, o.ce);
    else n_pass++;
  endtask

  task automatic test_random_short();
    obs_t o;
    logic [135:0] f;
    int mode;
    for (int k = 0; k < 6; k++) begin
      f = short_frame(6'($urandom), $urandom);
      mode = $urandom_range(0, 3);
      if (mode == 1) f[$urandom_range(8, 45)] ^= 1'b1;
      if (mode == 2) f[0] = 1'b0;
      if (mode == 3) f[46] = 1'b1;
      run_frame(f, 1'b0, $urandom_range(0, 8), -1, o);
      n_chk++;
      if ({o.data, o.crc, o.ce, o.fe, o.to} !== exp_status(f, 1'b0))
        $display("FAIL rand_short%0d: got %h want %h", k, {o.data, o.crc, o.ce, o.fe, o.to}, exp_status(f, 1'b0));
      else n_pass++;
      n_chk++;
      if ({o.done_pre, o.done, o.done_post, o.busy_post, o.busy_mid, o.held, o.pulses} !== TIM_OK)
        $display("FAIL rand_short%0d_timing: got %b want %b", k,
                 {o.done_pre, o.done, o.done_post, o.busy_post, o.busy_mid, o.held, o.pulses}, TIM_OK);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    logic early, pre, busy_seen;
    int c0;
    c0 = done_cnt;
    early = 1'b0;
    bus.long_resp = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    busy_seen = bus.busy;
    for (int i = 1; i < 64; i++) begin
      send_bit(1'b1);
      if (bus.done !== 1'b0) early = 1'b1;
    end
    bus.cmd_in = 1'b1;
    repeat (3) @(negedge clk);
    bus.tick = 1'b1;
    pre = bus.done;
    @(negedge clk);
    bus.tick = 1'b0;
    n_chk++;
    if (early !== 1'b0 || pre !== 1'b0 || busy_seen !== 1'b1)
      $display("FAIL timeout_early: got early=%b pre=%b busy=%b want 0 0 1", early, pre, busy_seen);
    else n_pass++;
    n_chk++;
    if ({bus.done, bus.timeout, bus.crc_err, bus.frame_err} !== 4'b1100)
      $display("FAIL timeout_flags: got done/to/ce/fe=%b want 1100", {bus.done, bus.timeout, bus.crc_err, bus.frame_err});
    else n_pass++;
    n_chk++;
    if (bus.resp_data !== '0 || bus.resp_crc !== '0)
      $display("FAIL timeout_data: got data=%h crc=%h want 0", bus.resp_data, bus.resp_crc);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.timeout !== 1'b1 || done_cnt - c0 != 1)
      $display("FAIL timeout_after: got busy=%b done=%b to=%b pulses=%0d want 0 0 1 1", bus.busy, bus.done,
               bus.timeout, done_cnt - c0);
    else n_pass++;
  endtask

  task automatic test_long();
    obs_t o;
    logic [135:0] f;
    for (int k = 0; k < 2; k++) begin
      f = long_frame({$urandom, $urandom, $urandom, $urandom});
      if (k == 1) f[$urandom_range(8, 127)] ^= 1'b1;
      run_frame(f, 1'b1, $urandom_range(0, 5), (k == 0) ? 70 : 20, o);
      n_chk++;
      if ({o.data, o.crc, o.ce, o.fe, o.to} !== exp_status(f, 1'b1))
        $display("FAIL long%0d_status: got %h want %h", k, {o.data, o.crc, o.ce, o.fe, o.to}, exp_status(f, 1'b1));
      else n_pass++;
      n_chk++;
      if ({o.done_pre, o.done, o.done_post, o.busy_post, o.busy_mid, o.held, o.pulses} !== TIM_OK)
        $display("FAIL long%0d_timing: got %b want %b", k,
                 {o.done_pre, o.done, o.done_post, o.busy_post, o.busy_mid, o.held, o.pulses}, TIM_OK);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    logic [135:0] f1, f2;
    f1 = short_frame(6'($urandom), $urandom);
    f2 = long_frame({$urandom, $urandom, $urandom, $urandom});
    run_frame(f1, 1'b0, 0, -1, o1);
    run_frame(f2, 1'b1, 0, -1, o2);
    n_chk++;
    if ({o1.data, o1.crc, o1.ce, o1.fe, o1.to} !== exp_status(f1, 1'b0))
      $display("FAIL b2b_first: got %h want %h", {o1.data, o1.crc, o1.ce, o1.fe, o1.to}, exp_status(f1, 1'b0));
    else n_pass++;
    n_chk++;
    if ({o2.data, o2.crc, o2.ce, o2.fe, o2.to} !== exp_status(f2, 1'b1))
      $display("FAIL b2b_second: got %h want %h", {o2.data, o2.crc, o2.ce, o2.fe, o2.to}, exp_status(f2, 1'b1));
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    obs_t o;
    logic [135:0] f;
    logic busy_pre, busy_seen;
    int c0;
    f = short_frame(6'($urandom), $urandom | 32'h0100_0000);
    bus.long_resp = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 47; i >= 21; i--) send_bit(f[i]);
    bus.cmd_in = f[20];
    @(negedge clk);
    busy_pre = bus.busy;
    reset = 1'b1;
    #1;
    n_chk++;
    if (busy_pre !== 1'b1 ||
        {bus.busy, bus.done, bus.resp_data, bus.resp_crc, bus.crc_err, bus.frame_err, bus.timeout} !== '0)
      $display("FAIL midframe_reset: got busy_pre=%b busy=%b done=%b data=%h crc=%h want busy_pre=1 rest 0",
               busy_pre, bus.busy, bus.done, bus.resp_data, bus.resp_crc);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    c0 = done_cnt;
    busy_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      send_bit((i % 3) == 0 ? 1'b0 : 1'b1);
      if (bus.busy !== 1'b0) busy_seen = 1'b1;
    end
    n_chk++;
    if (busy_seen !== 1'b0 || done_cnt != c0)
      $display("FAIL post_reset_idle: got busy_seen=%b pulses=%0d want 0 0", busy_seen, done_cnt - c0);
    else n_pass++;
    f = short_frame(6'($urandom), $urandom);
    run_frame(f, 1'b0, 2, -1, o);
    n_chk++;
    if ({o.data, o.crc, o.ce, o.fe, o.to} !== exp_status(f, 1'b0))
      $display("FAIL post_reset_frame: got %h want %h", {o.data, o.crc, o.ce, o.fe, o.to}, exp_status(f, 1'b0));
    else n_pass++;
    n_chk++;
    if ({o.done_pre, o.done, o.done_post, o.busy_post, o.busy_mid, o.held, o.pulses} !== TIM_OK)
      $display("FAIL post_reset_timing: got %b want %b",
               {o.done_pre, o.done, o.done_post, o.busy_post, o.busy_mid, o.held, o.pulses}, TIM_OK);
    else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    bus.tick = 1'b0;
    bus.cmd_in = 1'b1;
    bus.start = 1'b0;
    bus.long_resp = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_cmd0();
    test_short_valid();
    test_random_short();
    test_timeout();
    test_long();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
